// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared states, pc-select encodings and cause codes for the hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, LDSTALL, EXC_HOLD} state_t;
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_VEC = 2'd2;
  localparam logic [1:0] PC_EPC = 2'd3;
  localparam logic [4:0] EXC_INTR    = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
endpackage

// File: rtl/intr_arbiter.sv
// intr_arbiter: fixed-priority one-hot grant, lowest index wins
module intr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         valid
);
  assign valid = |req;
  // first set bit from index 0 upward takes the grant
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) if (req[i] && grant == '0) grant[i] = 1'b1;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect control for load-use, mispredict, exceptions and eret
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          N_INTR   = 4,
  parameter int          LOAD_LAT = 1,
  parameter logic [31:0] VEC_BASE = 32'h8000_0180
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_stall,
  input  logic [4:0]        ifid_rs_addr,
  input  logic [4:0]        ifid_rt_addr,
  input  logic [4:0]        idex_rd_addr,
  input  logic              idex_mem_read,
  input  logic              ex_branch_valid,
  input  logic [31:0]       ex_predicted_pc,
  input  logic [31:0]       ex_target_pc,
  input  logic [31:0]       exmem_pc,
  input  logic              exmem_syscall,
  input  logic              exmem_eret,
  input  logic [31:0]       epc_in,
  input  logic [N_INTR-1:0] intr_req,
  input  logic [N_INTR-1:0] intr_mask,
  output logic [1:0]        cu_pc_src,
  output logic              cu_pc_stall,
  output logic              cu_ifid_stall,
  output logic              cu_idex_stall,
  output logic              cu_exmem_stall,
  output logic              cu_ifid_flush,
  output logic              cu_idex_flush,
  output logic              cu_exmem_flush,
  output logic              cu_cp0_w_en,
  output logic [4:0]        cu_exec_code,
  output logic [31:0]       cu_epc,
  output logic [31:0]       cu_vector,
  output logic              bpu_write_en,
  output logic [N_INTR-1:0] cu_intr_ack,
  output logic              cu_exl
);
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic exl, exl_nx;
  logic [N_INTR-1:0] grant;
  logic intr_any, go, open, br_miss, hazard;
  logic exc, eret_take, mispred, load_use, ld_hold, hold;
  intr_arbiter #(.N(N_INTR)) u_arb (
    .req  (intr_req & intr_mask & {N_INTR{~exl}}),
    .grant(grant),
    .valid(intr_any)
  );
  assign go        = rst_n && !mem_stall;
  assign open      = go && state != EXC_HOLD;
  assign br_miss   = ex_branch_valid && ex_predicted_pc != ex_target_pc;
  assign hazard    = idex_mem_read && idex_rd_addr != 5'd0 &&
                     (idex_rd_addr == ifid_rs_addr || idex_rd_addr == ifid_rt_addr);
  assign exc       = open && (intr_any || exmem_syscall);
  assign eret_take = open && !exc && exmem_eret;
  assign mispred   = open && !exc && !exmem_eret && br_miss;
  assign load_use  = go && state == RUN && !exc && !exmem_eret && !br_miss && hazard;
  assign ld_hold   = go && state == LDSTALL && !exc && !exmem_eret && !br_miss;
  assign hold      = go && state == EXC_HOLD;
  // outputs are a pure function of state, exl and inputs; reset forces them quiet
  always_comb begin
    cu_pc_src      = exc ? PC_VEC : eret_take ? PC_EPC : mispred ? PC_BR : PC_SEQ;
    cu_pc_stall    = (rst_n && mem_stall) || load_use || ld_hold;
    cu_ifid_stall  = cu_pc_stall;
    cu_idex_stall  = rst_n && mem_stall;
    cu_exmem_stall = cu_idex_stall;
    cu_ifid_flush  = exc || eret_take || mispred || hold;
    cu_idex_flush  = cu_ifid_flush || load_use;
    cu_exmem_flush = exc || eret_take;
    cu_cp0_w_en    = exc;
    cu_exec_code   = (exc && !intr_any) ? EXC_SYSCALL : EXC_INTR;
    cu_epc         = exc ? exmem_pc : 32'd0;
    cu_vector      = VEC_BASE;
    bpu_write_en   = mispred;
    cu_intr_ack    = exc ? grant : '0;
    cu_exl         = exl;
  end
  // next state: exception > eret/mispredict/hold-exit > new load-use > LDSTALL countdown
  always_comb begin
    state_nx = !go ? state : exc ? EXC_HOLD :
               (state == EXC_HOLD || eret_take || mispred) ? RUN :
               load_use ? (LOAD_LAT > 1 ? LDSTALL : RUN) :
               ld_hold ? (cnt <= 3'd1 ? RUN : LDSTALL) : state;
    cnt_nx   = !go ? cnt : (load_use && LOAD_LAT > 1) ? 3'(LOAD_LAT - 1) :
               (ld_hold && cnt > 3'd1) ? cnt - 3'd1 : 3'd0;
    exl_nx   = !go ? exl : exc ? 1'b1 : eret_take ? 1'b0 : exl;
  end
  // state, stall counter and exception level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
      exl   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      exl   <= exl_nx;
    end
  end
  logic unused;
  assign unused = ^epc_in;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven single-cycle vectors plus multi-cycle sequences
module tb_pipe_hazard_ctrl;
  localparam logic [31:0] VEC = 32'h8000_0180;
  typedef struct packed {
    logic ms; logic [4:0] rs, rt, rd; logic mr, br;
    logic [31:0] pred, tgt, pc; logic sys, eret; logic [3:0] req, mask;
  } in_t;
  typedef struct packed {
    logic [1:0] src; logic [3:0] st; logic [2:0] fl; logic cp0; logic [4:0] code;
    logic [31:0] epc; logic bpu; logic [3:0] ack; logic exl;
  } out_t;
  typedef struct {string nm; in_t i; out_t o;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0, mem_stall, idex_mem_read, ex_branch_valid, exmem_syscall, exmem_eret;
  logic [4:0] ifid_rs_addr, ifid_rt_addr, idex_rd_addr, cu_exec_code;
  logic [31:0] ex_predicted_pc, ex_target_pc, exmem_pc, epc_in, cu_epc, cu_vector;
  logic [3:0] intr_req, intr_mask, cu_intr_ack;
  logic [1:0] cu_pc_src;
  logic cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall;
  logic cu_ifid_flush, cu_idex_flush, cu_exmem_flush, cu_cp0_w_en, bpu_write_en, cu_exl;
  int total = 0, bad = 0;
  vec_t vecs[$];
  pipe_hazard_ctrl #(.N_INTR(4), .LOAD_LAT(3), .VEC_BASE(VEC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall),
    .ifid_rs_addr(ifid_rs_addr), .ifid_rt_addr(ifid_rt_addr), .idex_rd_addr(idex_rd_addr),
    .idex_mem_read(idex_mem_read), .ex_branch_valid(ex_branch_valid),
    .ex_predicted_pc(ex_predicted_pc), .ex_target_pc(ex_target_pc), .exmem_pc(exmem_pc),
    .exmem_syscall(exmem_syscall), .exmem_eret(exmem_eret), .epc_in(epc_in),
    .intr_req(intr_req), .intr_mask(intr_mask), .cu_pc_src(cu_pc_src),
    .cu_pc_stall(cu_pc_stall), .cu_ifid_stall(cu_ifid_stall), .cu_idex_stall(cu_idex_stall),
    .cu_exmem_stall(cu_exmem_stall), .cu_ifid_flush(cu_ifid_flush), .cu_idex_flush(cu_idex_flush),
    .cu_exmem_flush(cu_exmem_flush), .cu_cp0_w_en(cu_cp0_w_en), .cu_exec_code(cu_exec_code),
    .cu_epc(cu_epc), .cu_vector(cu_vector), .bpu_write_en(bpu_write_en),
    .cu_intr_ack(cu_intr_ack), .cu_exl(cu_exl)
  );
  always #5 clk = ~clk;
  function automatic out_t o_(logic [1:0] src, logic [3:0] st, logic [2:0] fl, logic cp0,
                              logic [4:0] code, logic [31:0] epc, logic bpu, logic [3:0] ack, logic exl);
    return {src, st, fl, cp0, code, epc, bpu, ack, exl};
  endfunction
  task automatic apply(input in_t t);
    mem_stall = t.ms; ifid_rs_addr = t.rs; ifid_rt_addr = t.rt; idex_rd_addr = t.rd;
    idex_mem_read = t.mr; ex_branch_valid = t.br; ex_predicted_pc = t.pred; ex_target_pc = t.tgt;
    exmem_pc = t.pc; exmem_syscall = t.sys; exmem_eret = t.eret; intr_req = t.req; intr_mask = t.mask;
    epc_in = 32'h0040_0024;
  endtask
  task automatic check(input string nm, input out_t e);
    logic [84:0] a, x;
    a = {cu_pc_src, cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall, cu_ifid_flush,
         cu_idex_flush, cu_exmem_flush, cu_cp0_w_en, cu_exec_code, cu_epc, bpu_write_en,
         cu_intr_ack, cu_exl, cu_vector};
    x = {e, VEC};
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, a, x);
    end
  endtask
  task automatic step(input string nm, input in_t t, input out_t e);
    apply(t);
    #1 check(nm, e);
    @(negedge clk);
  endtask
  task automatic restart();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask
  task automatic add(input string nm, input in_t t, input out_t e);
    vec_t v;
    v.nm = nm; v.i = t; v.o = e;
    vecs.push_back(v);
  endtask
  initial begin
    in_t z, t, lu, mp, ir, sc, er, ms;
    out_t o_lu, o_mp, o_ir, o_sc, o_er, o_ms, o_st, o_hold;
    z = '0;
    lu = '0; lu.mr = 1'b1; lu.rd = 5'd4; lu.rs = 5'd4;
    mp = '0; mp.br = 1'b1; mp.pred = 32'h0040_0010; mp.tgt = 32'h0040_0100;
    ir = '0; ir.req = 4'b0110; ir.mask = 4'b1111; ir.pc = 32'h0040_0020;
    sc = '0; sc.sys = 1'b1; sc.pc = 32'h0040_0030;
    er = '0; er.eret = 1'b1;
    ms = '0; ms.ms = 1'b1;
    o_lu   = o_(2'd0, 4'b1100, 3'b010, 1'b0, 5'd0, 32'd0, 1'b0, 4'b0, 1'b0);
    o_mp   = o_(2'd1, 4'b0000, 3'b110, 1'b0, 5'd0, 32'd0, 1'b1, 4'b0, 1'b0);
    o_ir   = o_(2'd2, 4'b0000, 3'b111, 1'b1, 5'd0, 32'h0040_0020, 1'b0, 4'b0010, 1'b0);
    o_sc   = o_(2'd2, 4'b0000, 3'b111, 1'b1, 5'd8, 32'h0040_0030, 1'b0, 4'b0, 1'b0);
    o_er   = o_(2'd3, 4'b0000, 3'b111, 1'b0, 5'd0, 32'd0, 1'b0, 4'b0, 1'b0);
    o_ms   = o_(2'd0, 4'b1111, 3'b000, 1'b0, 5'd0, 32'd0, 1'b0, 4'b0, 1'b0);
    o_st   = o_(2'd0, 4'b1100, 3'b000, 1'b0, 5'd0, 32'd0, 1'b0, 4'b0, 1'b0);
    o_hold = o_(2'd0, 4'b0000, 3'b110, 1'b0, 5'd0, 32'd0, 1'b0, 4'b0, 1'b1);
    add("idle", z, '0);
    add("lu_rs", lu, o_lu);
    t = '0; t.mr = 1'b1; t.rd = 5'd7; t.rt = 5'd7; t.rs = 5'd1; add("lu_rt", t, o_lu);
    t = '0; t.mr = 1'b1; add("lu_r0", t, '0);
    t = lu; t.mr = 1'b0; add("lu_noread", t, '0);
    add("misp", mp, o_mp);
    t = mp; t.pred = 32'h0040_0100; add("br_ok", t, '0);
    add("misp_lu", mp | lu, o_mp);
    add("intr", ir, o_ir);
    t = ir; t.mask = 4'b1001; add("intr_masked", t, '0);
    t = ir; t.req = 4'b1110; t.mask = 4'b1100;
    add("intr_sel", t, o_(2'd2, 4'b0, 3'b111, 1'b1, 5'd0, 32'h0040_0020, 1'b0, 4'b0100, 1'b0));
    add("syscall", sc, o_sc);
    add("sys_misp", sc | mp, o_sc);
    add("intr_sys", ir | sc, o_(2'd2, 4'b0, 3'b111, 1'b1, 5'd0, 32'h0040_0030, 1'b0, 4'b0010, 1'b0));
    add("eret", er, o_er);
    add("eret_misp", er | mp, o_er);
    add("sys_eret", sc | er, o_sc);
    add("ms_sys", ms | sc | mp, o_ms);
    add("ms", ms, o_ms);
    add("ms_lu", ms | lu, o_ms);
    apply(ms | sc | mp | ir);
    #12 check("reset", '0);
    @(negedge clk);
    foreach (vecs[k]) begin
      restart();
      step(vecs[k].nm, vecs[k].i, vecs[k].o);
    end
    restart();
    step("ld_c1", lu, o_lu);
    step("ld_c2", z, o_st);
    step("ld_c3", z, o_st);
    step("ld_end", z, '0);
    step("ld_again", lu, o_lu);
    restart();
    step("ldm_c1", lu, o_lu);
    step("ldm_ms", ms, o_ms);
    step("ldm_c2", z, o_st);
    step("ldm_c3", z, o_st);
    step("ldm_end", z, '0);
    restart();
    step("ldb_c1", lu, o_lu);
    step("ldb_misp", mp, o_mp);
    step("ldb_end", z, '0);
    restart();
    step("ldr_c1", lu, o_lu);
    restart();
    step("ldr_run", z, '0);
    restart();
    step("ir_take", ir, o_ir);
    step("ir_hold", ir, o_hold);
    step("ir_ignored", ir, o_(2'd0, 4'b0, 3'b0, 1'b0, 5'd0, 32'd0, 1'b0, 4'b0, 1'b1));
    step("eret_exl", ir | er, o_(2'd3, 4'b0, 3'b111, 1'b0, 5'd0, 32'd0, 1'b0, 4'b0, 1'b1));
    step("ir_retake", ir, o_ir);
    step("ir_hold2", z, o_hold);
    restart();
    step("sc_take", sc, o_sc);
    step("sc_hold", sc | er, o_hold);
    step("sc_exl", sc, o_(2'd2, 4'b0, 3'b111, 1'b1, 5'd8, 32'h0040_0030, 1'b0, 4'b0, 1'b1));
    restart();
    step("ms_sc1", ms | sc, o_ms);
    step("ms_sc2", ms | sc, o_ms);
    step("ms_drop", sc, o_sc);
    step("ms_hold", z, o_hold);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N_INTR, 4, number of external interrupt lines (1..8).
  LOAD_LAT, 1, load-use stall cycles (1..4).
  VEC_BASE, 32'h8000_0180, exception vector address.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  mem_stall  in  1  memory not ready.
  ifid_rs_addr  in  5  ID source reg rs.
  ifid_rt_addr  in  5  ID source reg rt.
  idex_rd_addr  in  5  EX destination reg.
  idex_mem_read  in  1  EX instruction is a load.
  ex_branch_valid  in  1  branch/jump resolved this cycle.
  ex_predicted_pc  in  32  PC predicted at fetch.
  ex_target_pc  in  32  resolved PC.
  exmem_pc  in  32  PC of MEM-stage instruction.
  exmem_syscall  in  1  MEM-stage syscall.
  exmem_eret  in  1  MEM-stage eret.
  epc_in  in  32  CP0 EPC value.
  intr_req  in  N_INTR  level interrupt requests.
  intr_mask  in  N_INTR  1 = enabled.
  cu_pc_src  out  2  0 sequential/predicted, 1 ex_target_pc, 2 VEC_BASE, 3 epc_in.
  cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall  out  1 each  hold register.
  cu_ifid_flush, cu_idex_flush, cu_exmem_flush  out  1 each  insert bubble.
  cu_cp0_w_en  out  1  write EPC/cause.
  cu_exec_code  out  5  cause code.
  cu_epc  out  32  EPC to write.
  cu_vector  out  32  exception target.
  bpu_write_en  out  1  update predictor.
  cu_intr_ack  out  N_INTR  one-hot grant.
  cu_exl  out  1  exception level flag.

Function
REQ-003 States: RUN, LDSTALL, EXC_HOLD; plus flag exl.
REQ-004 Event priority per cycle: mem_stall > exception > eret > mispredict > load-use.
REQ-005 mem_stall=1: all four stall outputs 1, all flushes 0, cp0_w_en 0, bpu_write_en 0, state/counter/exl hold, events deferred.
REQ-006 Interrupt pending = |(intr_req & intr_mask) & ~exl; lowest index wins (fixed priority).
REQ-007 Exception (interrupt pending or exmem_syscall, state RUN/LDSTALL): same cycle cu_pc_src=2, all three flushes 1, cu_cp0_w_en=1, cu_epc=exmem_pc, cu_exec_code=0 (interrupt) or 8 (syscall), interrupt wins over syscall, cu_intr_ack one-hot for interrupt only; next state EXC_HOLD, exl<=1, LDSTALL counter cleared.
REQ-008 EXC_HOLD lasts exactly one cycle: ifid/idex flush 1, no new exception or eret accepted; returns to RUN.
REQ-009 exmem_eret in RUN/LDSTALL: cu_pc_src=3, all three flushes 1, exl<=0 on next edge; interrupts accepted from following cycle.
REQ-010 Mispredict (ex_branch_valid & predicted!=target): cu_pc_src=1, ifid/idex flush 1, bpu_write_en=1 for that cycle only; cancels any load-use stall in same cycle.
REQ-011 Load-use (RUN, idex_mem_read, idex_rd_addr!=0, equal to rs or rt): pc/ifid stall 1, idex flush 1; if LOAD_LAT>1 enter LDSTALL with counter LOAD_LAT-1, continuing pc/ifid stall each cycle until counter reaches 0, then RUN.
REQ-012 cu_vector constant VEC_BASE; cu_exec_code/cu_epc 0 when cu_cp0_w_en=0.
REQ-013 All outputs combinational from state, exl and inputs; no output-path latency.

Reset
REQ-014 rst_n low asynchronously forces state RUN, counter 0, exl 0; all outputs then 0 except cu_vector=VEC_BASE.
REQ-015 Reset mid-LDSTALL or EXC_HOLD aborts it; first cycle after release is RUN.

Structure
REQ-016 Package pipe_ctrl_pkg: state enum, pc_src encoding constants, exec codes (INTR=0, SYSCALL=8).
REQ-017 Sub-module intr_arbiter: N_INTR-wide fixed-priority one-hot grant plus valid.

Verification
REQ-018 idex_mem_read=1, rd=4, rs=4, LOAD_LAT=3 -> pc/ifid stall for 3 cycles, idex flush first cycle, back to RUN.
REQ-019 branch_valid, predicted 32'h0040_0010, target 32'h0040_0100 -> pc_src=1, ifid/idex flush, bpu_write_en one cycle.
REQ-020 intr_req=4'b0110, mask=4'b1111, exmem_pc=32'h0040_0020 -> ack=4'b0010, pc_src=2, cp0_w_en, epc 32'h0040_0020, code 0, exl=1; repeated request ignored.
REQ-021 syscall and mispredict same cycle -> exception only, code 8, bpu_write_en 0.
REQ-022 mem_stall=1 with syscall pending -> only stalls; syscall taken on cycle mem_stall drops.
REQ-023 eret with epc_in=32'h0040_0024 -> pc_src=3, all flushes, exl=0 next cycle; pending interrupt then taken.
